// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment display driver with a frame-synchronous load handshake.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 10000
) (
    input  logic                  sysclk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank,
    output logic                  busy,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            Cathodes
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]       psc_q, psc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0] pending_q, pending_d;
    logic [DIGITS-1:0]   pending_dp_q, pending_dp_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          cath_q, cath_d;

    logic                tick;
    logic                last_slot;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_lz;
    logic [DIGITS-1:0]   onehot;
    logic [DIGITS-1:0]   lz;
    logic                lz_run;

    // Active-high segment pattern, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1111110;
            4'h1: seg7 = 7'b0110000;
            4'h2: seg7 = 7'b1101101;
            4'h3: seg7 = 7'b1111001;
            4'h4: seg7 = 7'b0110011;
            4'h5: seg7 = 7'b1011011;
            4'h6: seg7 = 7'b1011111;
            4'h7: seg7 = 7'b1110000;
            4'h8: seg7 = 7'b1111111;
            4'h9: seg7 = 7'b1111011;
            4'hA: seg7 = 7'b1110111;
            4'hB: seg7 = 7'b0011111;
            4'hC: seg7 = 7'b1001110;
            4'hD: seg7 = 7'b0111101;
            4'hE: seg7 = 7'b1001111;
            default: seg7 = 7'b1000111;
        endcase
    endfunction

    assign tick      = (psc_q == PSC_LAST);
    assign last_slot = tick && (idx_q == IDX_LAST);

`ifdef SEG_LZB_EN
    // A digit is blank when it and every digit above it hold zero; digit 0 always shows.
    always_comb begin
        lz     = '0;
        lz_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lz_run = lz_run && (shadow_q[4*k +: 4] == 4'h0);
            lz[k]  = lz_run;
        end
    end
`else
    always_comb begin
        lz     = '0;
        lz_run = 1'b0;
    end
`endif

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        onehot  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = shadow_q[4*k +: 4];
                cur_dp    = shadow_dp_q[k];
                cur_lz    = lz[k];
                onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        psc_d        = tick ? '0 : psc_q + 1'b1;
        idx_d        = idx_q;
        an_d         = an_q;
        cath_d       = cath_q;
        frame_done_d = last_slot;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        pending_dp_d = pending_dp_q;
        busy_d       = busy_q;

        if (tick) begin
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            an_d   = ~onehot;
            cath_d = {(cur_lz ? 7'h7F : ~seg7(cur_nib)), ~cur_dp};
        end
        if (blank) begin
            an_d = '1;
        end

        // Shadow takes the old pending value; a load on the same edge waits another frame.
        if (last_slot && busy_q) begin
            shadow_d    = pending_q;
            shadow_dp_d = pending_dp_q;
            busy_d      = 1'b0;
        end
        if (load) begin
            pending_d    = data_in;
            pending_dp_d = dp_in;
            busy_d       = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            psc_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= '0;
            pending_dp_q <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= '1;
            cath_q       <= 8'hFF;
        end else begin
            psc_q        <= psc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            pending_dp_q <= pending_dp_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            cath_q       <= cath_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign AN         = an_q;
    assign Cathodes   = cath_q;

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed 7-segment digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 10000, sysclk cycles per digit slot (legal >=2).
REQ-003 SHALL have port sysclk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_in  input  4*DIGITS  hex nibbles; nibble k = digit k, digit 0 rightmost.
REQ-006 SHALL have port dp_in  input  DIGITS  decimal-point request per digit, captured with data_in.
REQ-007 SHALL have port load  input  1  one-cycle strobe requesting a display update.
REQ-008 SHALL have port blank  input  1  level; forces all anodes off while high.
REQ-009 SHALL have port busy  output  1  high while a loaded value awaits the frame boundary.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse on the last digit slot of each frame.
REQ-011 SHALL have port AN  output  DIGITS  anode enables, active-low, bit k = digit k.
REQ-012 SHALL have port Cathodes  output  8  active-low {a,b,c,d,e,f,g,dp}, bit 7 = a, bit 0 = dp.

Function
REQ-013 SHALL count a prescaler 0..SCAN_DIV-1 and wrap; tick = prescaler at SCAN_DIV-1.
REQ-014 On tick: AN <= ~onehot(idx), Cathodes <= decode(shadow nibble idx, shadow dp idx), idx <= idx+1, wrapping DIGITS-1 -> 0.
REQ-015 AN and Cathodes SHALL be registered and change only on tick edges (blank excepted); no glitch between ticks.
REQ-016 Decode SHALL be full hex 0-F, standard segment patterns; e.g. 0=8'h03, 4=8'h99, 5=8'h49, 8=8'h01 with dp off.
REQ-017 load=1 SHALL capture data_in/dp_in into pending and set busy on the next edge.
REQ-018 load while busy SHALL overwrite pending; last load wins; busy stays high.
REQ-019 On tick with idx=DIGITS-1: frame_done pulses one cycle; if busy, shadow <= pending and busy clears same edge.
REQ-020 load coinciding with REQ-019 transfer SHALL capture new pending and leave busy=1 (new value waits a full frame).
REQ-021 blank=1 SHALL drive AN all-ones combinationally-gated at output register next edge; scanning, prescaler, handshake continue.
REQ-022 DIGITS=1 SHALL hold AN[0] low each tick and pulse frame_done every tick.

Reset
REQ-023 reset_n low SHALL asynchronously clear prescaler, idx, shadow, pending, busy=0, frame_done=0.
REQ-024 During/after reset AN SHALL be all-ones and Cathodes 8'hFF until the first tick.
REQ-025 Reset mid-frame or mid-handshake SHALL discard pending; release restarts scan at digit 0.

Configuration
REQ-026 Macro SEG_LZB_EN defined: leading-zero blanking; digits above the most significant nonzero nibble show segments off (Cathodes[7:1]=all ones, dp still per dp_in); digit 0 never blanked.
REQ-027 SEG_LZB_EN undefined: every digit decoded per REQ-016, zeros shown.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-028 Reset asserted -> AN=4'b1111, Cathodes=8'hFF, busy=0, frame_done=0; hold 3 cycles after release, still unchanged.
REQ-029 load 16'h1234, dp_in=0 -> busy=1 until frame wrap; next frame AN 1110/1101/1011/0111 show 4,3,2,1; digit 4 Cathodes=8'h99.
REQ-030 Free-run -> AN changes exactly every 4 cycles; frame_done high 1 cycle every 16 cycles, coincident with AN=0111 update.
REQ-031 load 16'hAAAA then 16'h0000 two cycles apart within one frame -> busy held; following frame shows 0 on all digits (8'h03).
REQ-032 reset_n pulled low at digit 2 with busy=1 -> AN=1111, Cathodes=8'hFF, busy=0 immediately, no clock needed.
REQ-033 SEG_LZB_EN defined, load 16'h0050 -> digits 3,2 Cathodes=8'hFF, digit 1=8'h49, digit 0=8'h03; undefined -> digits 3,2=8'h03.
